// File: rtl/mem_ctr.sv
// mem_ctr -- main-memory controller on the cache's bus2 side.
//
// Stores whole cache lines and answers line READ/WRITE commands after a
// fixed latency. Lines move as little-endian bursts: beat k carries line
// bytes k*B .. k*B+B-1 (B = DATA2_BUS_SIZE/8), byte k*B+j on D2[8j+7:8j].
// Outputs come with separate enables; the wrapper above resolves them onto
// the shared tri-state bus.
//
// Ports:
//   CLK      in   clock, all state updates on posedge
//   RESET    in   asynchronous active-low reset
//   A2       in   line address, sampled in the command cycle
//   D2_IN    in   write data beat from the cache
//   D2_OUT   out  read data beat to the cache
//   D2_OE    out  memory drives D2
//   C2_IN    in   command from cache (0 NOP, 1 RESPONSE, 2 READ_LINE, 3 WRITE_LINE)
//   C2_OUT   out  command driven by memory (NOP or RESPONSE)
//   C2_OE    out  memory drives C2
//   RD_COUNT out  completed read responses, saturating   (MEM_STATS_EN only)
//   WR_COUNT out  completed write responses, saturating  (MEM_STATS_EN only)
//
// Build option: define MEM_STATS_EN to add the RD_COUNT/WR_COUNT counters.

module mem_ctr #(
   parameter int ADDR2_BUS_SIZE  = 10,
   parameter int DATA2_BUS_SIZE  = 16,
   parameter int CACHE_LINE_SIZE = 16,
   parameter int MEM_LATENCY     = 100
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [ADDR2_BUS_SIZE-1:0] A2,
   input  logic [DATA2_BUS_SIZE-1:0] D2_IN,
   output logic [DATA2_BUS_SIZE-1:0] D2_OUT,
   output logic                      D2_OE,
   input  logic [1:0]                C2_IN,
   output logic [1:0]                C2_OUT,
   output logic                      C2_OE
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]               RD_COUNT,
   output logic [15:0]               WR_COUNT
`endif
);

   localparam int DW     = DATA2_BUS_SIZE;
   localparam int LINE_W = CACHE_LINE_SIZE * 8;
   localparam int BEATS  = LINE_W / DW;
   localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
   localparam int BEAT_W = $clog2(BEATS + 1);
   localparam int DEPTH  = 2 ** ADDR2_BUS_SIZE;

   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_RESP  = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;

   generate
      if (MEM_LATENCY <= BEATS) begin : g_chk_latency
         $error("mem_ctr: MEM_LATENCY must be greater than the beat count");
      end
      if ((DW % 8 != 0) || (LINE_W % DW != 0)) begin : g_chk_width
         $error("mem_ctr: bus width must be a multiple of 8 dividing the line size");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, WR_RECV, WAIT, RESP_WR, RESP_RD} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;      // cycles elapsed since the command edge
   logic [BEAT_W-1:0]         beat_q;
   logic                      is_wr_q;
   logic                      commit_q;   // full write line waiting to enter the array
   logic [ADDR2_BUS_SIZE-1:0] addr_q;
   logic [LINE_W-1:0]         wbuf_q;
   logic [LINE_W-1:0]         wbuf_d;
   logic [LINE_W-1:0]         line_q;     // read line, shifted down one beat per cycle
   logic [LINE_W-1:0]         rd_data_q;
   logic                      rd_en;

   logic [LINE_W-1:0]         mem [DEPTH];

   // Incoming beats enter at the top and move down, so after the last beat
   // beat 0 sits in the low bits, matching the little-endian line layout.
   assign wbuf_d = (wbuf_q >> DW) | (LINE_W'(D2_IN) << (LINE_W - DW));
   assign rd_en  = (state_q == IDLE) && (C2_IN == CMD_READ);

   // Line array: no reset, registered read captured in the command cycle so
   // the response returns the line as it was when the read was accepted.
   always_ff @(posedge CLK) begin
      if (commit_q) begin
         mem[addr_q] <= wbuf_q;
      end
      if (rd_en) begin
         rd_data_q <= mem[A2];
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         beat_q   <= '0;
         is_wr_q  <= 1'b0;
         commit_q <= 1'b0;
         addr_q   <= '0;
         wbuf_q   <= '0;
         line_q   <= '0;
         D2_OUT   <= '0;
         D2_OE    <= 1'b0;
         C2_OUT   <= CMD_NOP;
         C2_OE    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (C2_IN == CMD_READ) begin
                  addr_q  <= A2;
                  is_wr_q <= 1'b0;
                  cnt_q   <= CNT_W'(1);
                  state_q <= WAIT;
               end else if (C2_IN == CMD_WRITE) begin
                  addr_q  <= A2;
                  is_wr_q <= 1'b1;
                  cnt_q   <= CNT_W'(1);
                  beat_q  <= BEAT_W'(1);
                  wbuf_q  <= wbuf_d;
                  if (BEATS == 1) begin
                     commit_q <= 1'b1;
                     state_q  <= WAIT;
                  end else begin
                     state_q  <= WR_RECV;
                  end
               end
            end
            WR_RECV: begin
               cnt_q  <= cnt_q + CNT_W'(1);
               beat_q <= beat_q + BEAT_W'(1);
               wbuf_q <= wbuf_d;
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  commit_q <= 1'b1;
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               // The commit pulse lasts exactly the first WAIT cycle.
               commit_q <= 1'b0;
               if (cnt_q == CNT_W'(MEM_LATENCY)) begin
                  C2_OE  <= 1'b1;
                  C2_OUT <= CMD_RESP;
                  if (is_wr_q) begin
                     state_q <= RESP_WR;
                  end else begin
                     state_q <= RESP_RD;
                     D2_OE   <= 1'b1;
                     D2_OUT  <= rd_data_q[DW-1:0];
                     line_q  <= rd_data_q >> DW;
                     beat_q  <= BEAT_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP_WR: begin
               C2_OE   <= 1'b0;
               C2_OUT  <= CMD_NOP;
               state_q <= IDLE;
            end
            RESP_RD: begin
               if (beat_q == BEAT_W'(BEATS)) begin
                  C2_OE   <= 1'b0;
                  C2_OUT  <= CMD_NOP;
                  D2_OE   <= 1'b0;
                  D2_OUT  <= '0;
                  state_q <= IDLE;
               end else begin
                  D2_OUT <= line_q[DW-1:0];
                  line_q <= line_q >> DW;
                  beat_q <= beat_q + BEAT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_STATS_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   // Counted on the edge that ends each response; aborted ones never get there.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if ((state_q == RESP_RD) && (beat_q == BEAT_W'(BEATS)) && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
         end
         if ((state_q == RESP_WR) && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
      end
   end

   assign RD_COUNT = rd_cnt_q;
   assign WR_COUNT = wr_cnt_q;
`endif

endmodule

// File: doc/mem_ctr.md
Name: mem_ctr

Overview:
- Main-memory controller on the cache's bus2 side; consumes the line read/write commands issued by the cache.
- Stores whole cache lines and models fixed access latency.
- Transfers lines as little-endian multi-beat bursts over the D2 data bus.
- Split-direction ports with output enables; the top-level wrapper resolves them onto the shared tri-state bus.

Parameters:
- ADDR2_BUS_SIZE, 10, line address width (tag+set); memory depth = 2**ADDR2_BUS_SIZE lines.
- DATA2_BUS_SIZE, 16, data bus width in bits; must be a multiple of 8.
- CACHE_LINE_SIZE, 16, line size in bytes; BEATS = CACHE_LINE_SIZE*8/DATA2_BUS_SIZE (default 8).
- MEM_LATENCY, 100, cycles from command cycle to first response cycle; must be > BEATS (elaboration-time $error otherwise).

Ports:
- CLK  input  1  clock, all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- A2  input  ADDR2_BUS_SIZE  line address, sampled in command cycle.
- D2_IN  input  DATA2_BUS_SIZE  write data beat from cache.
- D2_OUT  output  DATA2_BUS_SIZE  read data beat to cache.
- D2_OE  output  1  memory drives D2.
- C2_IN  input  2  command from cache: 0 NOP, 1 RESPONSE, 2 READ_LINE, 3 WRITE_LINE.
- C2_OUT  output  2  command driven by memory (NOP or RESPONSE).
- C2_OE  output  1  memory drives C2.

Behaviour:
- Reset (RESET=0, async): state IDLE, counters 0, D2_OUT=0, D2_OE=0, C2_OUT=NOP(0), C2_OE=0. Memory array not cleared. Reset mid-transaction aborts it; partially received write lines are discarded, not committed.
- Byte order: beat k carries line bytes k*B..k*B+B-1 (B = DATA2_BUS_SIZE/8); byte k*B+j sits in D2[8j+7:8j].
- States: IDLE, WR_RECV, WAIT, RESP_WR, RESP_RD.
- IDLE: posedge t0 with C2_IN=READ_LINE latches A2, loads latency counter, goes to WAIT. C2_IN=WRITE_LINE latches A2 and D2_IN as beat 0, goes to WR_RECV. NOP and RESPONSE are ignored.
- WR_RECV: samples D2_IN at posedges t0+1..t0+BEATS-1 into a line buffer. After the last beat, commits the full line to memory in one write and goes to WAIT. C2_IN is ignored during this state.
- WAIT: latency counter counts cycles since t0. At posedge t0+MEM_LATENCY it enters RESP_WR (for a write) or RESP_RD (for a read).
- RESP_WR: from posedge t0+MEM_LATENCY, C2_OE=1 and C2_OUT=RESPONSE for exactly 1 cycle, D2_OE=0. Next posedge returns to IDLE with C2_OE=0 and C2_OUT=NOP.
- RESP_RD: from posedge t0+MEM_LATENCY+k (k=0..BEATS-1), C2_OE=1, C2_OUT=RESPONSE, D2_OE=1, D2_OUT=beat k of the line. At posedge t0+MEM_LATENCY+BEATS all OEs drop, D2_OUT returns to 0 and the FSM goes to IDLE.
- Read data is the line value at the time of the command; any write that committed earlier is visible.
- Commands arriving in any non-IDLE state are ignored; there is no queueing. A new command is accepted at the first posedge in IDLE, i.e. the response's final cycle plus 1.
- Reading a never-written line returns 'x in simulation; no defined value.
- The same address for write then read is supported back-to-back.

Optional Feature:
- MEM_STATS_EN defined: adds ports RD_COUNT output 16 and WR_COUNT output 16.
  - Each counter increments by 1 when its response completes (RESP_RD last beat, or RESP_WR cycle).
  - Both reset to 0 on RESET=0 and saturate at 16'hFFFF.
  - A transaction aborted by reset is not counted.
- MEM_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-WAIT of a READ at cycle t0+50 → all OEs 0 and C2_OUT=0 immediately (async). A READ issued afterwards completes with full latency.
- WRITE_LINE to A2=10'h005, beats 16'h0100, 16'h0302, ..., 16'h0F0E → C2_OUT=RESPONSE, C2_OE=1 for exactly one cycle at t0+100, D2_OE stays 0.
- READ_LINE to 10'h005 after that write → C2_OE=D2_OE=1 at cycles t0+100..t0+107, D2_OUT=16'h0100, 16'h0302, ..., 16'h0F0E in order, then all OEs 0.
- READ issued during WAIT of a prior write (C2_IN=2 at t0+20) → ignored; only the write RESPONSE appears and the FSM returns to IDLE.
- Two writes to 10'h3FF and 10'h000 with distinct data, then reads of both → each returns its own data (address extremes, no aliasing).
- With MEM_STATS_EN: 3 writes and 2 reads → WR_COUNT=3, RD_COUNT=2; after RESET pulse both counters are 0.
